// File: rtl/mod_step_counter.sv
// Step counter with prescaler, up/down direction, programmable limit and
// wrap-or-saturate terminal behaviour; emits a one-cycle terminal-count pulse.
module mod_step_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] startVal,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] outVal,
  output logic             tc
);

  localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_step;
  logic             r_tc;
  logic             w_step;
  logic             w_term;

  // A step fires on the last enabled cycle of each prescale period.
  assign w_step = en && !load && (r_pre == PRE_LAST);

  always_comb begin
    w_pre_nxt = r_pre;
    if (load) begin
      w_pre_nxt = '0;
    end else if (en) begin
      w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
    end
  end

  // Terminal condition is evaluated on the pre-step value.
  always_comb begin
    w_term       = up ? (r_count >= limit) : (r_count == '0);
    w_count_step = r_count;
    if (up) begin
      if (w_term) begin
        w_count_step = sat ? limit : '0;
      end else begin
        w_count_step = r_count + WIDTH'(1);
      end
    end else begin
      if (w_term) begin
        w_count_step = sat ? '0 : limit;
      end else begin
        w_count_step = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt;
      if (load) begin
        r_count <= startVal;
        r_tc    <= 1'b0;
      end else if (w_step) begin
        r_count <= w_count_step;
        r_tc    <= w_term;
      end else begin
        r_tc    <= 1'b0;
      end
    end
  end

  assign outVal = r_count;
  assign tc     = r_tc;

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
Parametrised successor to the basic load/increment counter used for Morse timing.
- Adds: configurable width, a clock prescaler, runtime up/down direction, programmable modulus limit, wrap-or-saturate mode, clock enable, and a one-cycle terminal-count pulse.
- Sits under the timing/wrapper layer. It measures dot/dash/gap unit durations and sequences symbol positions.

Parameters:
WIDTH, 4, bit width of count, startVal and limit (legal 2..16).
PRESCALE, 1, number of enabled clk cycles per count step (legal 1..256; 1 = step on every enabled cycle).

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  asynchronous, active-low reset.
en  input  1  count enable; steps the prescaler.
load  input  1  synchronous load of startVal; overrides en.
startVal  input  WIDTH  value loaded on load.
limit  input  WIDTH  modulus top value; count range is 0..limit.
up  input  1  1 = count up, 0 = count down; sampled on every step.
sat  input  1  1 = saturate at terminal value, 0 = wrap.
outVal  output  WIDTH  registered count.
tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset (reset=0): asynchronous, takes effect immediately.
  - outVal=0, tc=0, internal prescaler pre=0.
  - Held while reset=0. Normal operation resumes on the first rising edge after release.
  - Reset mid-step discards any partial prescale.
- Priority at each rising edge is load > en step > hold.
- load=1:
  - outVal<=startVal, pre<=0, tc<=0.
  - en is ignored that cycle.
  - startVal > limit is allowed and is loaded verbatim.
- Prescaler:
  - While en=1 and load=0, pre counts 0..PRESCALE-1 and wraps to 0.
  - A step occurs on an edge where en=1 and pre==PRESCALE-1.
  - en=0 holds both pre and outVal.
  - PRESCALE=1: pre is constant 0 and every enabled edge is a step.
- Step, up=1:
  - outVal>=limit is the terminal condition:
    - sat=0: outVal<=0.
    - sat=1: outVal<=limit (clamps a value loaded above limit).
  - Otherwise outVal<=outVal+1.
- Step, up=0:
  - outVal==0 is the terminal condition:
    - sat=0: outVal<=limit.
    - sat=1: outVal holds at 0.
  - Otherwise outVal<=outVal-1. This also applies when outVal>limit.
- tc:
  - tc<=1 on every step edge where the terminal condition held before the step, including repeated steps while saturated.
  - tc<=0 on all other edges, including non-step edges, so it is high for exactly one clk cycle per terminal step.
- Latency: outVal and tc change on the same edge as the step. No combinational path from inputs to outputs.
- limit, up and sat are read combinationally at the step edge. Changing them mid-count takes effect on the next step with no restart.
- limit=0:
  - up wrap: outVal stays 0 with tc every step.
  - down wrap: 0 -> 0 with tc every step.
- Arithmetic is modulo 2^WIDTH internally. No overflow is reachable, because +1 occurs only when outVal<limit and -1 only when outVal>0.

Test Plan:
- WIDTH=4, PRESCALE=1: reset=0 then release, load=1 startVal=4'd4, then en=1 up=1 sat=0 limit=4'd6 -> outVal 4,5,6,0,1; tc high only on the edge producing 0.
- Same config, up=0, sat=0, load 4'd1 -> outVal 1,0,6,5; tc high only on the 0->6 edge.
- sat=1 up=1 limit=4'd3, from 2 -> outVal 3,3,3; tc high on each edge that holds at 3. Then load startVal=4'd9 and step once -> outVal 3 with tc=1.
- PRESCALE=3 instance, en=1 from outVal=0, limit=4'd15 -> outVal increments once every 3 clocks. Dropping en for 2 cycles mid-prescale delays the next step by exactly 2 clocks.
- Assert reset=0 asynchronously between edges while outVal=5 and tc=1 -> outVal=0 and tc=0 immediately, before the next edge. After release, the first step arrives PRESCALE enabled cycles later.
- load=1 and en=1 together at a terminal step -> outVal=startVal, tc=0, pre cleared.
